fetch_request_unit: RTL and testbench
=====================================

// Module: fetch_request_unit
// PURPOSE
//  Multi-cycle front end for the MIPS core. It owns the PC and fetches from instruction memory via an ihit handshake.
//  It holds the fetched word stable for control_unit decode, and sequences data-memory requests via a dhit handshake.
//  On completion it commits the next PC from control_unit's PCSel/branch outputs.
//  Sits between the memory interface and control_unit/datapath. Gates register-file writes via commit.
// PARAMETERS
//  PC_INIT   32'h0000_0000   PC value loaded on reset
// PORTS
//  CLK          in   1   core clock (single clock domain)
//  nRST         in   1   reset, synchronous, active-low
//  ihit         in   1   imem read complete; imemload valid this cycle
//  imemload     in   32  instruction word from imem
//  dhit         in   1   dmem access complete
//  PCSel        in   2   from control_unit: 00 jump, 01 branch, 10 JR, 11 pc+4
//  branchSel    in   1   0 = BEQ (taken if zero), 1 = BNE (taken if !zero)
//  zero         in   1   ALU zero flag
//  cu_dREN      in   1   decoded load
//  cu_dWEN      in   1   decoded store
//  cu_halt      in   1   decoded HALT
//  rdat1        in   32  rs value, JR target
//  iREN         out  1   imem read request
//  imemaddr     out  32  = pc
//  instr        out  32  latched instruction, feeds control_unit
//  dmemREN      out  1   dmem read request
//  dmemWEN      out  1   dmem write request
//  commit       out  1   1-cycle pulse: instruction retires; PC updates, regfile write allowed
//  pc           out  32  current PC
//  npc          out  32  pc + 4 (JAL link value)
//  halt         out  1   sticky halt indication
// BEHAVIOUR
//  Reset (nRST low at CLK edge; overrides all events, incl. mid-request):
//   - State goes to IFETCH; pc = PC_INIT; instr = 0; halt = 0.
//   - All request outputs deassert the following cycle.
//  FSM states: IFETCH, EXEC, DMEM, HALTED
//   IFETCH: iREN=1.
//     - ihit: instr <= imemload; -> EXEC.
//     - no ihit: hold, no timeout.
//   EXEC: instr stable; decode and ALU evaluate combinationally.
//     - cu_halt: -> HALTED; no commit; pc unchanged.
//     - else cu_dREN|cu_dWEN: -> DMEM.
//     - else: commit=1; pc <= next_pc; -> IFETCH.
//   DMEM: dmemWEN = cu_dWEN; dmemREN = cu_dREN & ~cu_dWEN (write wins if both).
//     - dhit (may arrive in the first DMEM cycle): commit=1; pc <= next_pc; -> IFETCH.
//     - Requests are held until dhit.
//   HALTED: absorbing until reset; halt=1; all requests 0; ihit/dhit ignored.
//  Latency: non-memory instruction = ihit cycle + 1 EXEC cycle.
//   Load/store adds DMEM cycles up to and including dhit.
//  next_pc (all 32-bit unsigned, wrap-around mod 2^32; 32'hFFFF_FFFC + 4 = 0):
//   00: {npc[31:28], instr[25:0], 2'b00}
//   01: taken ? npc + (sext(instr[15:0]) << 2) : npc
//        taken = branchSel ? ~zero : zero
//        imm is sign-extended here, regardless of control_unit's extension
//   10: {rdat1[31:2], 2'b00}   misaligned JR is silently aligned
//   11: npc
//  iREN, dmemREN, dmemWEN and commit are combinational from state plus inputs; no glitch requirement.
//  ihit in EXEC/DMEM and dhit in IFETCH/EXEC are ignored.
// STRUCTURE
//  - cpu_types_pkg gains: typedef enum logic [1:0] {IFETCH, EXEC, DMEM, HALTED} fetch_state_t;
//    also PCSEL_J=2'b00, PCSEL_BR=2'b01, PCSEL_JR=2'b10, PCSEL_NPC=2'b11.
//  - One combinational sub-module, pc_next_logic:
//    inputs pc, instr, PCSel, branchSel, zero, rdat1; output next_pc.
//  - This block keeps only the FSM plus the pc/instr/halt registers.
// TESTING
//  1. Reset: nRST=0 two cycles, PC_INIT=32'h40 -> pc=32'h40, iREN=1 first cycle after release, halt=0, commit=0.
//  2. ADDI from IFETCH, ihit after 3 cycles, PCSel=11 -> one EXEC cycle with commit=1; pc 0x40 -> 0x44; iREN next cycle.
//  3. BNE, pc=0x100, imm=16'hFFFE, zero=0 -> pc=0xFC; repeat with zero=1 -> pc=0x104; BEQ mirrors.
//  4. LW with dhit after 4 DMEM cycles -> dmemREN held 4 cycles, commit only on the dhit cycle, pc+4;
//     SW with dhit in the first cycle -> dmemWEN one cycle.
//  5. JR rdat1=32'h203 -> pc=0x200.
//     J at pc=0xF000_0000 with target 26'h3FF_FFFF -> pc=0xFFFF_FFFC.
//     Then PCSel=11 -> pc wraps to 0.
//  6. HALT -> halt=1 stays through 10 cycles of random ihit/dhit, pc frozen, no commit.
//     nRST=0 during a pending DMEM -> dmemREN=0 next cycle, state IFETCH.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the multi-cycle core front end: fetch FSM states, PCSel codes
// and the branch-offset helper used when forming the next PC.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IFETCH = 2'b00,
        EXEC   = 2'b01,
        DMEM   = 2'b10,
        HALTED = 2'b11
    } fetch_state_t;

    localparam logic [1:0] PCSEL_J   = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JR  = 2'b10;
    localparam logic [1:0] PCSEL_NPC = 2'b11;

    // Branch immediates are always sign-extended here, independent of the
    // extension mode control_unit picks for the ALU operand.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection (jump / branch / JR / pc+4), modulo 2^32.
// Zero latency, no handshake; result only matters on the commit cycle.
module pc_next_logic
    import cpu_types_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  PCSel,
    input  logic        branchSel,
    input  logic        zero,
    input  logic [31:0] rdat1,
    output logic [31:0] next_pc
);

    logic [31:0] w_npc;
    logic        w_taken;
    logic        w_unused;

    assign w_npc    = pc + 32'd4;
    assign w_taken  = branchSel ? ~zero : zero;
    assign w_unused = ^{instr[31:26], rdat1[1:0]};

    always_comb begin
        next_pc = w_npc;
        case (PCSel)
            PCSEL_J:   next_pc = {w_npc[31:28], instr[25:0], 2'b00};
            PCSEL_BR:  next_pc = w_taken ? (w_npc + br_offset(instr[15:0])) : w_npc;
            PCSEL_JR:  next_pc = {rdat1[31:2], 2'b00};
            default:   next_pc = w_npc;
        endcase
    end

endmodule

// File: rtl/fetch_request_unit.sv
// Multi-cycle fetch/exec/dmem sequencer owning PC, latched instruction and halt.
// Latency: ihit cycle + 1 EXEC (+ DMEM cycles through dhit); waits indefinitely on ihit/dhit.
module fetch_request_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        dhit,
    input  logic [1:0]  PCSel,
    input  logic        branchSel,
    input  logic        zero,
    input  logic        cu_dREN,
    input  logic        cu_dWEN,
    input  logic        cu_halt,
    input  logic [31:0] rdat1,
    output logic        iREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        commit,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        halt
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_halt;
    logic [31:0]  w_next_pc;

    pc_next_logic u_pc_next (
        .pc        (r_pc),
        .instr     (r_instr),
        .PCSel     (PCSel),
        .branchSel (branchSel),
        .zero      (zero),
        .rdat1     (rdat1),
        .next_pc   (w_next_pc)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IFETCH;
            r_pc    <= PC_INIT;
            r_instr <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (commit) begin
                r_pc <= w_next_pc;
            end
            if (r_state == IFETCH && ihit) begin
                r_instr <= imemload;
            end
            if (w_state_nxt == HALTED) begin
                r_halt <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        iREN        = 1'b0;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        commit      = 1'b0;
        case (r_state)
            IFETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cu_halt) begin
                    w_state_nxt = HALTED;
                end else if (cu_dREN || cu_dWEN) begin
                    w_state_nxt = DMEM;
                end else begin
                    commit      = 1'b1;
                    w_state_nxt = IFETCH;
                end
            end
            DMEM: begin
                // A store wins if decode flags both directions.
                dmemWEN = cu_dWEN;
                dmemREN = cu_dREN & ~cu_dWEN;
                if (dhit) begin
                    commit      = 1'b1;
                    w_state_nxt = IFETCH;
                end
            end
            default: begin
                w_state_nxt = HALTED;
            end
        endcase
    end

    assign pc       = r_pc;
    assign imemaddr = r_pc;
    assign npc      = r_pc + 32'd4;
    assign instr    = r_instr;
    assign halt     = r_halt;

endmodule

// File: tb/tb_fetch_request_unit.sv
// Transaction-level bench: each instruction is fetched, executed and retired against
// a PC model computed directly from the next-PC rules, with directed and random cases.
module tb_fetch_request_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic [1:0]  PCSel;
    logic        branchSel;
    logic        zero;
    logic        cu_dREN;
    logic        cu_dWEN;
    logic        cu_halt;
    logic [31:0] rdat1;
    logic        iREN;
    logic [31:0] imemaddr;
    logic [31:0] instr;
    logic        dmemREN;
    logic        dmemWEN;
    logic        commit;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        halt;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] m_pc;

    always #5 CLK = ~CLK;

    fetch_request_unit #(.PC_INIT(32'h0000_0040)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .ihit      (ihit),
        .imemload  (imemload),
        .dhit      (dhit),
        .PCSel     (PCSel),
        .branchSel (branchSel),
        .zero      (zero),
        .cu_dREN   (cu_dREN),
        .cu_dWEN   (cu_dWEN),
        .cu_halt   (cu_halt),
        .rdat1     (rdat1),
        .iREN      (iREN),
        .imemaddr  (imemaddr),
        .instr     (instr),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .commit    (commit),
        .pc        (pc),
        .npc       (npc),
        .halt      (halt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] ref_next(logic [31:0] p, logic [31:0] w, logic [1:0] ps,
                                             logic bs, logic z, logic [31:0] rd1);
        logic [31:0] np;
        int          off;
        np = p + 32'd4;
        case (ps)
            2'd0: return (np & 32'hF000_0000) | (32'(w[25:0]) * 4);
            2'd1: begin
                off = int'($signed(w[15:0])) * 4;
                if (bs ? !z : z) return np + 32'(off);
                return np;
            end
            2'd2: return rd1 & 32'hFFFF_FFFC;
            default: return np;
        endcase
    endfunction

    // One full instruction: iw idle fetch cycles, ihit, EXEC, then dw_cyc DMEM
    // cycles without dhit before the dhit cycle (memory ops only).
    task automatic run_instr(input int iw, input logic [31:0] word, input logic [1:0] ps,
                             input logic bs, input logic z, input logic dr, input logic dw,
                             input logic hl, input logic [31:0] rd1, input int dw_cyc);
        logic [31:0] nxt;
        logic        e_ren;
        e_ren     = dr & ~dw;
        PCSel     = ps;
        branchSel = bs;
        zero      = z;
        cu_dREN   = dr;
        cu_dWEN   = dw;
        cu_halt   = hl;
        rdat1     = rd1;
        for (int i = 0; i < iw; i++) begin
            ihit     = 1'b0;
            dhit     = 1'($urandom_range(0, 1));
            imemload = $urandom;
            #1;
            chk("if_iren", iREN, 1);
            chk("if_commit", commit, 0);
            chk("if_dmem", {dmemREN, dmemWEN}, 0);
            chk("if_pc", pc, m_pc);
            chk("if_addr", imemaddr, m_pc);
            step();
        end
        ihit     = 1'b1;
        imemload = word;
        dhit     = 1'($urandom_range(0, 1));
        #1;
        chk("hit_iren", iREN, 1);
        chk("hit_commit", commit, 0);
        step();
        ihit     = 1'($urandom_range(0, 1));
        imemload = $urandom;
        dhit     = 1'($urandom_range(0, 1));
        #1;
        chk("ex_instr", instr, word);
        chk("ex_iren", iREN, 0);
        chk("ex_npc", npc, m_pc + 32'd4);
        nxt = ref_next(m_pc, word, ps, bs, z, rd1);
        if (hl) begin
            chk("ex_halt_commit", commit, 0);
            step();
            chk("halt_set", halt, 1);
            chk("halt_pc", pc, m_pc);
            return;
        end
        if (dr || dw) begin
            chk("ex_mem_commit", commit, 0);
            chk("ex_mem_dmem", {dmemREN, dmemWEN}, 0);
            step();
            for (int j = 0; j < dw_cyc; j++) begin
                dhit = 1'b0;
                ihit = 1'($urandom_range(0, 1));
                #1;
                chk("dm_ren", dmemREN, e_ren);
                chk("dm_wen", dmemWEN, dw);
                chk("dm_commit", commit, 0);
                chk("dm_pc", pc, m_pc);
                step();
            end
            dhit = 1'b1;
            #1;
            chk("dhit_ren", dmemREN, e_ren);
            chk("dhit_wen", dmemWEN, dw);
            chk("dhit_commit", commit, 1);
            step();
        end else begin
            chk("ex_commit", commit, 1);
            step();
        end
        m_pc = nxt;
        ihit = 1'b0;
        dhit = 1'b0;
        #1;
        chk("ret_pc", pc, m_pc);
        chk("ret_iren", iREN, 1);
        chk("ret_commit", commit, 0);
        chk("ret_halt", halt, 0);
    endtask

    localparam logic [31:0] J_100 = {6'h02, 26'h000_0040};

    initial begin
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; imemload = '0;
        PCSel = 2'b11; branchSel = 1'b0; zero = 1'b0;
        cu_dREN = 1'b0; cu_dWEN = 1'b0; cu_halt = 1'b0; rdat1 = '0;
        step();
        step();
        nRST = 1'b1;
        #1;
        m_pc = 32'h0000_0040;
        chk("rst_pc", pc, 32'h40);
        chk("rst_iren", iREN, 1);
        chk("rst_halt", halt, 0);
        chk("rst_commit", commit, 0);
        chk("rst_instr", instr, 0);

        run_instr(3, 32'h2008_0005, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        chk("addi_pc", pc, 32'h44);

        run_instr(0, J_100, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        run_instr(1, 32'h1500_FFFE, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        chk("bne_taken", pc, 32'hFC);
        run_instr(0, J_100, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 32'h1500_FFFE, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        chk("bne_not", pc, 32'h104);
        run_instr(0, J_100, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        run_instr(2, 32'h1100_FFFE, 2'b01, 0, 1, 0, 0, 0, 0, 0);
        chk("beq_taken", pc, 32'hFC);
        run_instr(0, J_100, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 32'h1100_FFFE, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        chk("beq_not", pc, 32'h104);

        run_instr(1, 32'h8C01_0000, 2'b11, 0, 0, 1, 0, 0, 0, 3);
        chk("lw_pc", pc, 32'h108);
        run_instr(0, 32'hAC01_0000, 2'b11, 0, 0, 0, 1, 0, 0, 0);
        chk("sw_pc", pc, 32'h10C);

        run_instr(0, 32'h0000_0008, 2'b10, 0, 0, 0, 0, 0, 32'h203, 0);
        chk("jr_pc", pc, 32'h200);
        run_instr(0, 32'h0000_0008, 2'b10, 0, 0, 0, 0, 0, 32'hF000_0000, 0);
        run_instr(0, 32'h0BFF_FFFF, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("j_top", pc, 32'hFFFF_FFFC);
        run_instr(0, 32'h2008_0001, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap", pc, 32'h0);

        for (int k = 0; k < 40; k++) begin
            logic mem;
            mem = ($urandom_range(0, 2) == 0);
            run_instr(int'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      mem & 1'($urandom_range(0, 1)), mem & 1'($urandom_range(0, 1)) | (mem & 1'($urandom_range(0,1))),
                      1'b0, $urandom, int'($urandom_range(0, 3)));
        end

        run_instr(1, 32'hFFFF_FFFF, 2'b00, 0, 0, 1, 0, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            ihit     = 1'($urandom_range(0, 1));
            dhit     = 1'($urandom_range(0, 1));
            imemload = $urandom;
            #1;
            chk("hlt_halt", halt, 1);
            chk("hlt_pc", pc, m_pc);
            chk("hlt_commit", commit, 0);
            chk("hlt_req", {iREN, dmemREN, dmemWEN}, 0);
            step();
        end

        nRST = 1'b0;
        step();
        nRST = 1'b1;
        m_pc = 32'h40;
        cu_halt = 1'b0; cu_dREN = 1'b1; cu_dWEN = 1'b0;
        ihit = 1'b1; imemload = 32'h8C01_0000; dhit = 1'b0;
        step();
        ihit = 1'b0;
        step();
        #1;
        chk("pend_ren", dmemREN, 1);
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        #1;
        chk("rst_dm_ren", dmemREN, 0);
        chk("rst_dm_iren", iREN, 1);
        chk("rst_dm_pc", pc, 32'h40);
        chk("rst_dm_halt", halt, 0);
        chk("rst_dm_instr", instr, 0);
        run_instr(1, 32'h2008_0002, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_pc", pc, 32'h44);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
